// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order instruction fetch with one outstanding read and redirect handling
module fetch_unit #(
  parameter int unsigned       xlen_p     = 32,
  parameter logic [xlen_p-1:0] reset_pc_p = 'h4000_0000
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                redirect_i,
  input  logic [xlen_p-1:0]   redirect_pc_i,
  output logic [xlen_p-1:0]   imem_addr_o,
  output logic                imem_read_o,
  input  logic                imem_resp_i,
  input  logic [xlen_p-1:0]   imem_rdata_i,
  output logic [2*xlen_p-1:0] iq_data_o,
  output logic                iq_valid_o,
  input  logic                iq_ready_i
);

  // REQ: read outstanding; HOLD: packet waiting for the queue;
  // DISCARD: read outstanding whose data is stale because of a redirect.
  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [xlen_p-1:0]   pc_q, pc_d;
  logic [xlen_p-1:0]   next_pc_q, next_pc_d;
  logic [2*xlen_p-1:0] out_q, out_d;
  logic [xlen_p-1:0]   redirect_tgt;

  // Instructions are word aligned, so the low two target bits are cleared.
  assign redirect_tgt = redirect_pc_i & ~xlen_p'(3);

  assign imem_addr_o = pc_q;
  assign imem_read_o = (state_q != ST_HOLD);
  assign iq_valid_o  = (state_q == ST_HOLD);
  assign iq_data_o   = out_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_REQ;
      pc_q      <= reset_pc_p;
      next_pc_q <= reset_pc_p;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      next_pc_q <= next_pc_d;
      out_q     <= out_d;
    end
  end

  // Next-state logic: capture responses, advance the PC, and retire stale reads.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    out_d     = out_q;
    unique case (state_q)
      ST_REQ: begin
        if (imem_resp_i && !redirect_i) begin
          out_d   = {pc_q, imem_rdata_i};
          state_d = ST_HOLD;
        end else if (redirect_i && !imem_resp_i) begin
          // The read cannot be withdrawn; remember the target and wait it out.
          next_pc_d = redirect_tgt;
          state_d   = ST_DISCARD;
        end else if (redirect_i && imem_resp_i) begin
          // Read completes this cycle, so the new fetch can start immediately.
          pc_d = redirect_tgt;
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          // The packet is dropped even if the queue is ready; the queue flushes too.
          pc_d    = redirect_tgt;
          state_d = ST_REQ;
        end else if (iq_ready_i) begin
          pc_d    = pc_q + xlen_p'(4);
          state_d = ST_REQ;
        end
      end
      ST_DISCARD: begin
        if (redirect_i) begin
          next_pc_d = redirect_tgt;
        end
        if (imem_resp_i) begin
          pc_d    = redirect_i ? redirect_tgt : next_pc_q;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic        imem_read_o;
  logic        imem_resp_i;
  logic [31:0] imem_rdata_i;
  logic [63:0] iq_data_o;
  logic        iq_valid_o;
  logic        iq_ready_i;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] pushed[$];

  fetch_unit dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_addr_o  (imem_addr_o),
    .imem_read_o  (imem_read_o),
    .imem_resp_i  (imem_resp_i),
    .imem_rdata_i (imem_rdata_i),
    .iq_data_o    (iq_data_o),
    .iq_valid_o   (iq_valid_o),
    .iq_ready_i   (iq_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Records every packet the queue would accept at this edge.
  always @(posedge clk_i) begin
    if (reset_n_i && iq_valid_o && iq_ready_i && !redirect_i)
      pushed.push_back(iq_data_o);
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_resp_i = 1'b0; imem_rdata_i = '0; iq_ready_i = 1'b0;
    tick(); tick();
    reset_n_i = 1'b1;
    pushed.delete();
  endtask

  // One-cycle memory response followed by an immediate queue accept.
  task automatic fetch_one(input logic [31:0] data);
    imem_resp_i = 1'b1; imem_rdata_i = data;
    tick();
    imem_resp_i = 1'b0; iq_ready_i = 1'b1;
    tick();
    iq_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_resp_i = 1'b0; imem_rdata_i = '0; iq_ready_i = 1'b0;
    tick(); tick();
    n_cmp++; if (iq_valid_o !== 1'b0) begin $display("FAIL reset_valid got %b want 0", iq_valid_o); n_bad++; end
    n_cmp++; if (imem_addr_o !== 32'h4000_0000) begin $display("FAIL reset_addr got %h want 40000000", imem_addr_o); n_bad++; end
    reset_n_i = 1'b1;
    pushed.delete();
    n_cmp++; if (imem_read_o !== 1'b1) begin $display("FAIL reset_read got %b want 1", imem_read_o); n_bad++; end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    exp_pc = 32'h4000_0000;
    iq_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (imem_read_o !== 1'b1 || imem_addr_o !== exp_pc) begin
        $display("FAIL stream_read%0d got read=%b addr=%h want 1 %h", i, imem_read_o, imem_addr_o, exp_pc); n_bad++; end
      imem_resp_i = 1'b1; imem_rdata_i = 32'h0000_0013;
      tick();
      imem_resp_i = 1'b0;
      n_cmp++; if (iq_valid_o !== 1'b1 || iq_data_o !== {exp_pc, 32'h0000_0013} || imem_read_o !== 1'b0) begin
        $display("FAIL stream_pkt%0d got v=%b d=%h r=%b want 1 %h 0", i, iq_valid_o, iq_data_o, imem_read_o, {exp_pc, 32'h13}); n_bad++; end
      tick();
      exp_pc = exp_pc + 32'd4;
    end
    iq_ready_i = 1'b0;
    n_cmp++; if (pushed.size() != 3 || pushed[2] !== 64'h4000_0008_0000_0013) begin
      $display("FAIL stream_count got %0d want 3", pushed.size()); n_bad++; end
  endtask

  task automatic test_backpressure();
    // Continues from pc 4000_000C in REQ.
    imem_resp_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; iq_ready_i = 1'b0;
    tick();
    imem_resp_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (iq_valid_o !== 1'b1 || iq_data_o !== 64'h4000_000C_DEAD_BEEF || imem_read_o !== 1'b0) begin
        $display("FAIL hold%0d got v=%b d=%h r=%b want 1 4000000cdeadbeef 0", i, iq_valid_o, iq_data_o, imem_read_o); n_bad++; end
      tick();
    end
    iq_ready_i = 1'b1;
    tick();
    iq_ready_i = 1'b0;
    n_cmp++; if (imem_read_o !== 1'b1 || imem_addr_o !== 32'h4000_0010 || iq_valid_o !== 1'b0) begin
      $display("FAIL hold_resume got r=%b a=%h v=%b want 1 40000010 0", imem_read_o, imem_addr_o, iq_valid_o); n_bad++; end
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    fetch_one(32'h0000_0001);
    fetch_one(32'h0000_0002);
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0102;
    tick();
    redirect_i = 1'b0;
    n_cmp++; if (imem_read_o !== 1'b1 || imem_addr_o !== 32'h4000_0008) begin
      $display("FAIL disc_hold1 got r=%b a=%h want 1 40000008", imem_read_o, imem_addr_o); n_bad++; end
    tick();
    n_cmp++; if (imem_read_o !== 1'b1 || imem_addr_o !== 32'h4000_0008 || iq_valid_o !== 1'b0) begin
      $display("FAIL disc_hold2 got r=%b a=%h v=%b want 1 40000008 0", imem_read_o, imem_addr_o, iq_valid_o); n_bad++; end
    imem_resp_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
    tick();
    imem_resp_i = 1'b0;
    n_cmp++; if (imem_read_o !== 1'b1 || imem_addr_o !== 32'h8000_0100 || iq_valid_o !== 1'b0) begin
      $display("FAIL disc_newaddr got r=%b a=%h v=%b want 1 80000100 0", imem_read_o, imem_addr_o, iq_valid_o); n_bad++; end
    imem_resp_i = 1'b1; imem_rdata_i = 32'h0000_0011;
    tick();
    imem_resp_i = 1'b0;
    n_cmp++; if (iq_valid_o !== 1'b1 || iq_data_o !== 64'h8000_0100_0000_0011) begin
      $display("FAIL disc_pkt got v=%b d=%h want 1 8000010000000011", iq_valid_o, iq_data_o); n_bad++; end
    iq_ready_i = 1'b1;
    tick();
    iq_ready_i = 1'b0;
    n_cmp++; if (pushed.size() != 3 || pushed[2] !== 64'h8000_0100_0000_0011) begin
      $display("FAIL disc_pushed got n=%0d want 3", pushed.size()); n_bad++; end
    for (int i = 0; i < pushed.size(); i++) begin
      n_cmp++; if (pushed[i][31:0] === 32'hBAD0_BAD0) begin
        $display("FAIL disc_stale got %h want no stale data", pushed[i]); n_bad++; end
    end
  endtask

  task automatic test_redirect_with_resp();
    do_reset();
    fetch_one(32'h0000_0001);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_3003;
    imem_resp_i = 1'b1; imem_rdata_i = 32'hBAD1_BAD1;
    tick();
    redirect_i = 1'b0; imem_resp_i = 1'b0;
    n_cmp++; if (imem_read_o !== 1'b1 || imem_addr_o !== 32'h0000_3000 || iq_valid_o !== 1'b0) begin
      $display("FAIL same_cycle got r=%b a=%h v=%b want 1 00003000 0", imem_read_o, imem_addr_o, iq_valid_o); n_bad++; end
    iq_ready_i = 1'b1;
    tick();
    iq_ready_i = 1'b0;
    n_cmp++; if (iq_valid_o !== 1'b0 || pushed.size() != 1) begin
      $display("FAIL same_cycle_drop got v=%b n=%0d want 0 1", iq_valid_o, pushed.size()); n_bad++; end
    fetch_one(32'h0000_0022);
    n_cmp++; if (pushed.size() != 2 || pushed[1] !== 64'h0000_3000_0000_0022) begin
      $display("FAIL same_cycle_pkt got n=%0d want 2 with 0000300000000022", pushed.size()); n_bad++; end
  endtask

  task automatic test_double_redirect();
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_1000;
    tick();
    redirect_pc_i = 32'h0000_2000;
    tick();
    redirect_i = 1'b0;
    n_cmp++; if (imem_read_o !== 1'b1 || imem_addr_o !== 32'h4000_0000) begin
      $display("FAIL dbl_hold got r=%b a=%h want 1 40000000", imem_read_o, imem_addr_o); n_bad++; end
    imem_resp_i = 1'b1; imem_rdata_i = 32'hBAD2_BAD2;
    tick();
    imem_resp_i = 1'b0;
    n_cmp++; if (imem_addr_o !== 32'h0000_2000 || iq_valid_o !== 1'b0) begin
      $display("FAIL dbl_target got a=%h v=%b want 00002000 0", imem_addr_o, iq_valid_o); n_bad++; end
    fetch_one(32'h0000_0044);
    n_cmp++; if (pushed.size() != 1 || pushed[0] !== 64'h0000_2000_0000_0044) begin
      $display("FAIL dbl_pkt got n=%0d want 1 with 0000200000000044", pushed.size()); n_bad++; end
  endtask

  task automatic test_hold_redirect_wrap();
    do_reset();
    imem_resp_i = 1'b1; imem_rdata_i = 32'h0000_0055;
    tick();
    imem_resp_i = 1'b0;
    iq_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    tick();
    redirect_i = 1'b0; iq_ready_i = 1'b0;
    n_cmp++; if (pushed.size() != 0 || imem_read_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin
      $display("FAIL hold_redir got n=%0d r=%b a=%h want 0 1 fffffffc", pushed.size(), imem_read_o, imem_addr_o); n_bad++; end
    imem_resp_i = 1'b1; imem_rdata_i = 32'h0000_0033;
    tick();
    imem_resp_i = 1'b0;
    n_cmp++; if (iq_valid_o !== 1'b1 || iq_data_o !== 64'hFFFF_FFFC_0000_0033) begin
      $display("FAIL wrap_pkt got v=%b d=%h want 1 fffffffc00000033", iq_valid_o, iq_data_o); n_bad++; end
    iq_ready_i = 1'b1;
    tick();
    iq_ready_i = 1'b0;
    n_cmp++; if (imem_read_o !== 1'b1 || imem_addr_o !== 32'h0000_0000) begin
      $display("FAIL wrap_addr got r=%b a=%h want 1 00000000", imem_read_o, imem_addr_o); n_bad++; end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_with_resp();
    test_double_redirect();
    test_hold_redirect_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
